// File: rtl/ripple_borrow_subtractor_seq_pkg.sv
// Shared state encoding and sizing helpers for the sequential ripple-borrow subtractor.
// Optional feature macro used by the top: SUB_OVERFLOW_EN.
package ripple_borrow_subtractor_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DEFAULT_CHAINNUMBER = 8;
  localparam int DEFAULT_SLICE       = 2;

  // Width of a counter that indexes nSlices slices; never narrower than one bit.
  function automatic int sliceCntWidth(input int nSlices);
    return (nSlices > 1) ? $clog2(nSlices) : 1;
  endfunction

endpackage

// File: rtl/ripple_borrow_subtractor_seq_fullsub.sv
// One-bit full subtractor cell; SLICE copies form the per-cycle ripple-borrow chain.
module fullsubtractor_1
  import ripple_borrow_subtractor_seq_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic bout,
  output logic d
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/ripple_borrow_subtractor_seq.sv
// Sequential subtractor resolving SLICE bits per clock through a ripple-borrow chain.
// Define SUB_OVERFLOW_EN to add the registered signed Overflow output.
module ripple_borrow_subtractor_seq
  import ripple_borrow_subtractor_seq_pkg::*;
#(
  parameter int CHAINNUMBER = DEFAULT_CHAINNUMBER,
  parameter int SLICE       = DEFAULT_SLICE
) (
  input  logic                   clk1,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [CHAINNUMBER-1:0] X,
  input  logic [CHAINNUMBER-1:0] Y,
  input  logic                   Borrowin,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [CHAINNUMBER-1:0] Diff,
  output logic                   Borrowout
`ifdef SUB_OVERFLOW_EN
  ,
  output logic                   Overflow
`endif
);

  localparam int NSLICES = CHAINNUMBER / SLICE;
  localparam int CNT_W   = sliceCntWidth(NSLICES);
  localparam logic [CNT_W-1:0] LAST_SLICE = CNT_W'(NSLICES - 1);

  state_e state_q, state_d;

  logic [CHAINNUMBER-1:0] minuend_q, minuend_d;
  logic [CHAINNUMBER-1:0] subtrahend_q, subtrahend_d;
  logic [CHAINNUMBER-1:0] diff_q, diff_d;
  logic                   borrow_q, borrow_d;
  logic [CNT_W-1:0]       sliceCnt_q, sliceCnt_d;

  logic [SLICE-1:0]       sliceA, sliceB, sliceDiff;
  logic [SLICE:0]         borrowChain;
  logic [CHAINNUMBER-1:0] minuendShift, subtrahendShift, diffShift;
  logic                   accept, lastSlice;

  assign accept    = in_valid & in_ready;
  assign lastSlice = (sliceCnt_q == LAST_SLICE);

  // Operands shift right each RUN cycle so the active slice always sits in the low bits.
  assign sliceA         = minuend_q[SLICE-1:0];
  assign sliceB         = subtrahend_q[SLICE-1:0];
  assign borrowChain[0] = borrow_q;

  for (genvar i = 0; i < SLICE; i++) begin : gCell
    fullsubtractor_1 uCell (
      .a    (sliceA[i]),
      .b    (sliceB[i]),
      .bin  (borrowChain[i]),
      .bout (borrowChain[i+1]),
      .d    (sliceDiff[i])
    );
  end

  // Result bits enter at the top so after NSLICES shifts the LSB slice lands at bit 0.
  if (CHAINNUMBER > SLICE) begin : gShift
    assign minuendShift    = {{SLICE{1'b0}}, minuend_q[CHAINNUMBER-1:SLICE]};
    assign subtrahendShift = {{SLICE{1'b0}}, subtrahend_q[CHAINNUMBER-1:SLICE]};
    assign diffShift       = {sliceDiff, diff_q[CHAINNUMBER-1:SLICE]};
  end else begin : gSingle
    assign minuendShift    = '0;
    assign subtrahendShift = '0;
    assign diffShift       = sliceDiff;
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept)    state_d = RUN;
      RUN:     if (lastSlice) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  always_comb begin
    minuend_d    = minuend_q;
    subtrahend_d = subtrahend_q;
    diff_d       = diff_q;
    borrow_d     = borrow_q;
    sliceCnt_d   = sliceCnt_q;
    if (accept) begin
      minuend_d    = X;
      subtrahend_d = Y;
      borrow_d     = Borrowin;
      sliceCnt_d   = '0;
    end else if (state_q == RUN) begin
      minuend_d    = minuendShift;
      subtrahend_d = subtrahendShift;
      diff_d       = diffShift;
      borrow_d     = borrowChain[SLICE];
      sliceCnt_d   = lastSlice ? '0 : sliceCnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      minuend_q    <= '0;
      subtrahend_q <= '0;
      diff_q       <= '0;
      borrow_q     <= 1'b0;
      sliceCnt_q   <= '0;
    end else begin
      minuend_q    <= minuend_d;
      subtrahend_q <= subtrahend_d;
      diff_q       <= diff_d;
      borrow_q     <= borrow_d;
      sliceCnt_q   <= sliceCnt_d;
    end
  end

`ifdef SUB_OVERFLOW_EN
  logic overflow_q, overflow_d;

  // In the final cycle the low slice holds the original MSBs of both operands.
  always_comb begin
    overflow_d = overflow_q;
    if (state_q == RUN && lastSlice) begin
      overflow_d = (minuend_q[SLICE-1] != subtrahend_q[SLICE-1]) &
                   (sliceDiff[SLICE-1] != minuend_q[SLICE-1]);
    end
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= overflow_d;
    end
  end

  assign Overflow = overflow_q;
`endif

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign Diff      = diff_q;
  assign Borrowout = borrow_q;

endmodule
